tqvp_pwm_fade_ctrl: RTL and testbench



---
 rtl/tqvp_pwm_fade_pkg.sv | 47 ++++
 rtl/tqvp_pwm_fade_chan.sv | 59 +++++
 rtl/tqvp_pwm_fade_ctrl.sv | 172 +++++++++++++++++
 tb/tb_tqvp_pwm_fade_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tqvp_pwm_fade_pkg.sv
// Shared definitions for the four-channel PWM fade controller.
// Latency: n/a (constants and one combinational helper).
// Backpressure: n/a.
//
// Contents: register address map, ctrl bit positions, period wrap value and
// the saturating step-toward-target helper used by every channel.
package tqvp_pwm_fade_pkg;

  localparam logic [3:0] ADDR_TARGET0  = 4'd0;
  localparam logic [3:0] ADDR_TARGET1  = 4'd1;
  localparam logic [3:0] ADDR_TARGET2  = 4'd2;
  localparam logic [3:0] ADDR_TARGET3  = 4'd3;
  localparam logic [3:0] ADDR_CURRENT0 = 4'd4;
  localparam logic [3:0] ADDR_CURRENT1 = 4'd5;
  localparam logic [3:0] ADDR_CURRENT2 = 4'd6;
  localparam logic [3:0] ADDR_CURRENT3 = 4'd7;
  localparam logic [3:0] ADDR_RATE     = 4'd8;
  localparam logic [3:0] ADDR_CTRL     = 4'd9;
  localparam logic [3:0] ADDR_STATUS   = 4'd10;
  localparam logic [3:0] ADDR_DONE     = 4'd11;

  localparam int CTRL_ENABLE_BIT  = 0;
  localparam int CTRL_INSTANT_BIT = 1;

  // Last count value of a PWM period; the counter runs 0..PWM_WRAP.
  localparam logic [7:0] PWM_WRAP = 8'hFE;

  // Move cur one step toward tgt without passing it. Comparisons are done
  // at 9 bits so cur+step can never wrap past 255.
  function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [8:0] step);
    logic [8:0] c9;
    logic [8:0] t9;
    logic [7:0] res;
    c9  = {1'b0, cur};
    t9  = {1'b0, tgt};
    res = cur;
    if (c9 < t9) begin
      res = ((c9 + step) < t9) ? (cur + step[7:0]) : tgt;
    end else if (c9 > t9) begin
      res = (c9 > (t9 + step)) ? (cur - step[7:0]) : tgt;
    end
    return res;
  endfunction

endpackage

// File: rtl/tqvp_pwm_fade_chan.sv
// One fade channel: live level register, step/clamp toward target, PWM compare.
// Latency: level updates on the tick edge; pwm is registered, one cycle after count.
// Backpressure: none; ld and tick are single-cycle strobes, ld wins over tick.
//
// Ports: clk/rst (sync, active-high); en = block enable; tick = ramp step
// strobe; ld/ld_val = instant level load; tgt = target level; count = shared
// period counter; cur = live level; pwm = registered output; reached = this
// tick lands the level exactly on tgt.
module tqvp_pwm_fade_chan
  import tqvp_pwm_fade_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       tick,
  input  logic       ld,
  input  logic [7:0] ld_val,
  input  logic [7:0] tgt,
  input  logic [7:0] count,
  output logic [7:0] cur,
  output logic       pwm,
  output logic       reached
);

  localparam logic [8:0] STEP9 = 9'(STEP);

  logic [7:0] cur_q, cur_d;
  logic [7:0] stepped;
  logic       pwm_q, pwm_d;

  always_comb begin
    stepped = step_toward(cur_q, tgt, STEP9);
    cur_d   = cur_q;
    if (ld) begin
      cur_d = ld_val;
    end else if (tick) begin
      cur_d = stepped;
    end
    // count tops out at 254, so level 255 is high for the whole period.
    pwm_d   = en && (count < cur_q);
    reached = tick && !ld && (cur_q != tgt) && (stepped == tgt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cur_q <= cur_d;
      pwm_q <= pwm_d;
    end
  end

  assign cur = cur_q;
  assign pwm = pwm_q;

endmodule

// File: rtl/tqvp_pwm_fade_ctrl.sv
// Four-channel PWM fade controller for the TinyQV peripheral bus.
// Latency: register writes take effect next cycle; reads are combinational; outputs registered.
// Backpressure: none; every bus write is accepted in its cycle.
//
// Ports: clk, rst (sync, active-high); ui_in reserved; uo_out = {0, done_any,
// all_idle, period_start, pwm[3:0]}; address/data_write/data_in = register
// write port; data_out = combinational read of address.
// Optional build macro PWM_FADE_DONE_FLAGS_EN adds sticky per-channel done
// flags at address 11 and their OR on uo_out[6].
module tqvp_pwm_fade_ctrl
  import tqvp_pwm_fade_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int STEP   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  logic [NUM_CH-1:0][7:0] target_q, target_d;
  logic [7:0]             rate_q, rate_d;
  logic [1:0]             ctrl_q, ctrl_d;
  logic [7:0]             count_q, count_d;
  logic [7:0]             presc_q, presc_d;
  logic                   start_q, start_d;
  logic                   idle_q, idle_d;

  logic [NUM_CH-1:0][7:0] cur;
  logic [NUM_CH-1:0]      pwm;
  logic [NUM_CH-1:0]      reached;
  logic [NUM_CH-1:0]      ld;
  logic [NUM_CH-1:0]      status;
  logic                   enable, instant, period_end, tick;
  logic                   done_out;
  logic [7:0]             done_rd;

  logic unused_ui;
  assign unused_ui = ^ui_in;

  assign enable     = ctrl_q[CTRL_ENABLE_BIT];
  assign instant    = ctrl_q[CTRL_INSTANT_BIT];
  assign period_end = enable && (count_q == PWM_WRAP);
  assign tick       = period_end && (presc_q == rate_q);

  always_comb begin
    target_d = target_q;
    rate_d   = rate_q;
    ctrl_d   = ctrl_q;
    ld       = '0;
    status   = '0;
    if (data_write) begin
      if (address == ADDR_RATE) rate_d = data_in;
      if (address == ADDR_CTRL) ctrl_d = data_in[1:0];
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (data_write && (address == ADDR_TARGET0 + 4'(i))) begin
        target_d[i] = data_in;
        ld[i]       = instant;
      end
      status[i] = (cur[i] != target_q[i]);
    end

    // Disabled: counter and prescaler sit at 0 so re-enable starts cleanly.
    count_d = '0;
    presc_d = '0;
    if (enable) begin
      count_d = period_end ? 8'd0 : count_q + 8'd1;
      presc_d = presc_q;
      if (period_end) begin
        // A rate below the current prescaler lets it run on and wrap at 255.
        presc_d = tick ? 8'd0 : presc_q + 8'd1;
      end
    end

    start_d = period_end;
    idle_d  = ~|status;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_q <= '0;
      rate_q   <= '0;
      ctrl_q   <= '0;
      count_q  <= '0;
      presc_q  <= '0;
      start_q  <= 1'b0;
      idle_q   <= 1'b0;
    end else begin
      target_q <= target_d;
      rate_q   <= rate_d;
      ctrl_q   <= ctrl_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
      start_q  <= start_d;
      idle_q   <= idle_d;
    end
  end

  // Channels see the pre-write target, so a tick coinciding with a
  // non-instant target write still steps toward the old value.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    tqvp_pwm_fade_chan #(.STEP(STEP)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (enable),
      .tick    (tick),
      .ld      (ld[g]),
      .ld_val  (data_in),
      .tgt     (target_q[g]),
      .count   (count_q),
      .cur     (cur[g]),
      .pwm     (pwm[g]),
      .reached (reached[g])
    );
  end

`ifdef PWM_FADE_DONE_FLAGS_EN
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] done_clr;
  logic              done_any_q, done_any_d;

  always_comb begin
    done_clr   = (data_write && (address == ADDR_DONE)) ? data_in[NUM_CH-1:0] : '0;
    // Set after clear so a same-cycle arrival is never lost.
    done_d     = (done_q & ~done_clr) | reached;
    done_any_d = |done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q     <= '0;
      done_any_q <= 1'b0;
    end else begin
      done_q     <= done_d;
      done_any_q <= done_any_d;
    end
  end

  assign done_out = done_any_q;
  assign done_rd  = {{(8-NUM_CH){1'b0}}, done_q};
`else
  logic unused_reached;
  assign unused_reached = |reached;
  assign done_out       = 1'b0;
  assign done_rd        = 8'h00;
`endif

  always_comb begin
    data_out = '0;
    case (address)
      ADDR_RATE:   data_out = rate_q;
      ADDR_CTRL:   data_out = {6'b0, ctrl_q};
      ADDR_STATUS: data_out = {{(8-NUM_CH){1'b0}}, status};
      ADDR_DONE:   data_out = done_rd;
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (address == ADDR_TARGET0 + 4'(i))  data_out = target_q[i];
          if (address == ADDR_CURRENT0 + 4'(i)) data_out = cur[i];
        end
      end
    endcase
  end

  assign uo_out = {1'b0, done_out, idle_q, start_q, pwm};

endmodule

// File: tb/tb_tqvp_pwm_fade_ctrl.sv
// Bench for tqvp_pwm_fade_ctrl: a STEP=1 instance and a STEP=16 instance share
// the bus; stimulus queues expected samples, a negedge monitor compares them.
module tb_tqvp_pwm_fade_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [3:0] address = 4'd0;
  logic       data_write = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] uo_out, data_out, uo_out16, data_out16;

  always #5 clk = ~clk;

  tqvp_pwm_fade_ctrl #(.NUM_CH(4), .STEP(1)) dut (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out), .address(address),
    .data_write(data_write), .data_in(data_in), .data_out(data_out)
  );

  tqvp_pwm_fade_ctrl #(.NUM_CH(4), .STEP(16)) dut16 (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out16), .address(address),
    .data_write(data_write), .data_in(data_in), .data_out(data_out16)
  );

  // sel: 0 = dut read, 1 = dut uo_out & mask, 2 = bench measurement, 3 = dut16 read
  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] mask;
    logic [7:0] exp;
  } exp_t;

  exp_t       exp_q[$];
  string      nm_q[$];
  logic       smp_vld = 1'b0;
  logic [7:0] meas = 8'h00;
  int         checks = 0;
  int         failures = 0;

  exp_t       mon_e;
  string      mon_nm;
  logic [7:0] mon_got;

  always @(negedge clk) begin
    if (smp_vld) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty: sample with no expectation");
      end else begin
        mon_e  = exp_q.pop_front();
        mon_nm = nm_q.pop_front();
        case (mon_e.sel)
          2'd0:    mon_got = data_out;
          2'd1:    mon_got = uo_out & mon_e.mask;
          2'd2:    mon_got = meas;
          default: mon_got = data_out16;
        endcase
        if (mon_got !== mon_e.exp) begin
          failures++;
          $display("FAIL %s: got 0x%02h expected 0x%02h", mon_nm, mon_got, mon_e.exp);
        end
      end
    end
  end

  task automatic chk(input logic [1:0] sel, input logic [3:0] a, input logic [7:0] mask,
                     input logic [7:0] e, input string nm);
    exp_t x;
    x.sel  = sel;
    x.mask = mask;
    x.exp  = e;
    address = a;
    exp_q.push_back(x);
    nm_q.push_back(nm);
    smp_vld = 1'b1;
    @(posedge clk); #1;
    smp_vld = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e, input string nm);
    chk(2'd0, a, 8'hFF, e, nm);
  endtask

  task automatic rd16(input logic [3:0] a, input logic [7:0] e, input string nm);
    chk(2'd3, a, 8'hFF, e, nm);
  endtask

  task automatic uo(input logic [7:0] mask, input logic [7:0] e, input string nm);
    chk(2'd1, 4'd0, mask, e, nm);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address    = a;
    data_in    = d;
    data_write = 1'b1;
    @(posedge clk); #1;
    data_write = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns #1 into the cycle where the period-start pulse is high.
  task automatic wait_start();
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(posedge clk); #1;
      seen = uo_out[4];
    end
    if (!seen) uo(8'h10, 8'h10, "start_timeout");
  endtask

  task automatic count_pwm(input int b, input logic [7:0] e, input string nm);
    int n;
    n = 0;
    repeat (255) begin
      if (uo_out[b]) n++;
      @(posedge clk); #1;
    end
    meas = 8'(n);
    chk(2'd2, 4'd0, 8'h00, e, nm);
  endtask

  initial begin
    // Reset
    @(posedge clk); #1;
    uo(8'hFF, 8'h00, "rst_uo");
    rst = 1'b0;
    for (int a = 0; a < 16; a++) rd(4'(a), 8'h00, $sformatf("rst_rd%0d", a));
    uo(8'hFF, 8'h20, "rst_idle");

    // Ramp up, STEP 1, rate 0
    wr(4'd0, 8'd3);
    wr(4'd8, 8'd0);
    wr(4'd9, 8'h01);
    wait_start();
    rd(4'd4, 8'd1, "up1");
    rd(4'd10, 8'h01, "st_busy");
    uo(8'h20, 8'h00, "busy_idle");
    wait_start();
    rd(4'd4, 8'd2, "up2");
    wait_start();
    rd(4'd4, 8'd3, "up3");
    rd(4'd10, 8'h00, "st_done");
    uo(8'h20, 8'h20, "done_idle");
`ifdef PWM_FADE_DONE_FLAGS_EN
    rd(4'd11, 8'h01, "done0_set");
    uo(8'h40, 8'h40, "done_out");
`else
    rd(4'd11, 8'h00, "a11_zero");
    uo(8'h40, 8'h00, "done_out_zero");
`endif
    wr(4'd11, 8'h01);
    rd(4'd11, 8'h00, "done_clr");
    wr(4'd4, 8'd99);
    rd(4'd4, 8'd3, "cur_ro");
    wait_start();
    uo(8'h01, 8'h00, "pwm_c0");
    uo(8'h01, 8'h01, "pwm_c1");
    step(2);
    uo(8'h01, 8'h00, "pwm_c4");
    count_pwm(0, 8'd3, "pwm_cnt3");

    // Ramp down: instant 40, then target 10 at rate 1
    wait_start();
    wr(4'd9, 8'h03);
    wr(4'd1, 8'd40);
    wr(4'd9, 8'hFD);
    wr(4'd1, 8'd10);
    wr(4'd8, 8'd1);
    rd(4'd9, 8'h01, "ctrl_rd");
    rd(4'd5, 8'd40, "inst40");
    rd16(4'd5, 8'd40, "inst40_s16");
    wait_start();
    rd(4'd5, 8'd40, "dn_p1");
    rd16(4'd5, 8'd40, "dn_p1_s16");
    wait_start();
    rd(4'd5, 8'd39, "dn_p2");
    rd16(4'd5, 8'd24, "dn_p2_s16");
    wait_start();
    wait_start();
    rd(4'd5, 8'd38, "dn_p4");
    rd16(4'd5, 8'd10, "dn_p4_s16");
    wait_start();
    wait_start();
    rd16(4'd5, 8'd10, "floor_s16");
    rd16(4'd10, 8'h00, "st_s16");
    rd(4'd10, 8'h02, "st_ch1");

    // Boundary levels and a target write coinciding with a tick
    wr(4'd9, 8'h03);
    wr(4'd2, 8'd255);
    step(3);
    count_pwm(2, 8'd255, "pwm_full");
    wr(4'd2, 8'd0);
    step(3);
    count_pwm(2, 8'd0, "pwm_zero");
    rd(4'd6, 8'd0, "cur2_zero");
    wr(4'd9, 8'h00);
    wr(4'd8, 8'd0);
    wr(4'd9, 8'h01);
    step(254);
    wr(4'd2, 8'd1);
    rd(4'd6, 8'd0, "tick_old_tgt");
    wr(4'd11, 8'h0F);
    step(252);
    wr(4'd11, 8'h04);
    rd(4'd6, 8'd1, "tick_new_tgt");
`ifdef PWM_FADE_DONE_FLAGS_EN
    rd(4'd11, 8'h04, "set_wins");
`else
    rd(4'd11, 8'h00, "a11_zero2");
`endif

    // Disable mid-ramp
    wait_start();
    wr(4'd9, 8'h03);
    wr(4'd3, 8'd50);
    wr(4'd9, 8'h01);
    wr(4'd3, 8'd200);
    wr(4'd9, 8'h00);
    step(2);
    rd(4'd7, 8'd50, "dis_cur");
    uo(8'h1F, 8'h00, "dis_out");
    step(300);
    rd(4'd7, 8'd50, "dis_hold");
    wr(4'd8, 8'd1);
    wr(4'd9, 8'h01);
    wait_start();
    rd(4'd7, 8'd50, "reen_p1");
    wait_start();
    rd(4'd7, 8'd51, "reen_p2");

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
